cache_fill_fsm: RTL and testbench

Miss-handling responder between the pipelined core's cache lookup and multi-cycle main memory. On a miss reported by the I- or D-cache, it stalls the pipeline and issues a burst of consecutive word reads for the aligned block. It steers each returned word into the cache data array, then writes the tag and releases the stall. One instance serves each cache; arbitration between instances is outside this block.

---
 rtl/cache_fill_fsm.sv | 131 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : Cache miss fill sequencer: burst-reads an aligned block, writes the data array, then the tag.
//            Optional perf counters enabled by CACHE_FILL_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  output logic                           fsm_busy,
`ifdef CACHE_FILL_PERF_CNT_EN
  output logic [15:0]                    fill_count,
  output logic [15:0]                    busy_cycles,
`endif
  output logic                           memory_read_en,
  output logic [ADDR_W-1:0]              memory_address,
  input  logic                           memory_data_valid,
  input  logic [DATA_W-1:0]              memory_data,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
  output logic [DATA_W-1:0]              fill_data,
  output logic                           write_tag_array,
  output logic [ADDR_W-1:0]              fill_block_addr
);

  localparam int c_off_w = $clog2(BLOCK_WORDS);
  localparam int c_cnt_w = c_off_w + 1;
  localparam logic [ADDR_W-1:0]  c_align_mask = ~ADDR_W'(2 * BLOCK_WORDS - 1);
  localparam logic [c_cnt_w-1:0] c_words      = c_cnt_w'(BLOCK_WORDS);
  localparam logic [c_cnt_w-1:0] c_last       = c_cnt_w'(BLOCK_WORDS - 1);
  localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_base, w_base_nxt;
  logic [c_cnt_w-1:0]  r_issue_cnt, w_issue_nxt;
  logic [c_cnt_w-1:0]  r_recv_cnt, w_recv_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_issue_cnt <= w_issue_nxt;
      r_recv_cnt  <= w_recv_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_issue_nxt      = r_issue_cnt;
    w_recv_nxt       = r_recv_cnt;
    fsm_busy         = 1'b0;
    memory_read_en   = 1'b0;
    memory_address   = r_base + (ADDR_W'(r_issue_cnt) << 1);
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Combinational stall so the pipeline freezes in the miss cycle itself.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          w_state_nxt = ST_FILL;
          w_base_nxt  = miss_address & c_align_mask;
          w_issue_nxt = '0;
          w_recv_nxt  = '0;
        end
      end
      ST_FILL: begin
        fsm_busy = 1'b1;
        if (r_issue_cnt < c_words) begin
          memory_read_en = 1'b1;
          w_issue_nxt    = r_issue_cnt + c_one;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          w_recv_nxt       = r_recv_cnt + c_one;
          if (r_recv_cnt == c_last) begin
            write_tag_array = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign fill_word_idx   = r_recv_cnt[c_off_w-1:0];
  assign fill_data       = memory_data;
  assign fill_block_addr = r_base;

`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] r_fill_count;
  logic [15:0] r_busy_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_count  <= '0;
      r_busy_cycles <= '0;
    end else begin
      if (write_tag_array && (r_fill_count != 16'hFFFF))
        r_fill_count <= r_fill_count + 16'd1;
      if (fsm_busy && (r_busy_cycles != 16'hFFFF))
        r_busy_cycles <= r_busy_cycles + 16'd1;
    end
  end

  assign fill_count  = r_fill_count;
  assign busy_cycles = r_busy_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ============================================================================
// Module   : tb_cache_fill_fsm
// Purpose  : Directed self-checking bench for cache_fill_fsm with a latency-4 memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [15:0] fill_block_addr;
`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] fill_count;
  logic [15:0] busy_cycles;
`endif

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
`ifdef CACHE_FILL_PERF_CNT_EN
    .fill_count        (fill_count),
    .busy_cycles       (busy_cycles),
`endif
    .memory_read_en    (memory_read_en),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .fill_word_idx     (fill_word_idx),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_block_addr   (fill_block_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] a;
  } ent_t;

  ent_t q[$];
  int   cyc        = 0;
  int   checks     = 0;
  int   errors     = 0;
  int   reads_seen = 0;
  int   tags_seen  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, present any due memory return, log issued reads.
  task automatic step(input logic miss, input logic [15:0] addr);
    @(posedge clk);
    #1;
    cyc++;
    miss_detected = miss;
    miss_address  = addr;
    if (q.size() > 0 && q[0].due == cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = q[0].a ^ 16'h5A5A;
      void'(q.pop_front());
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'h0000;
    end
    #1;
    if (memory_read_en) begin
      q.push_back(ent_t'{due: cyc + LAT, a: memory_address});
      reads_seen++;
    end
    if (write_tag_array) tags_seen++;
  endtask

  task automatic do_fill(input logic [15:0] maddr, input logic [15:0] base);
    for (int k = 0; k <= 13; k++) begin
      step(k == 0, (k == 0) ? maddr : 16'h0000);
      chk("busy", fsm_busy, k <= 12);
      chk("rd_en", memory_read_en, (k >= 1 && k <= 8));
      if (k >= 1 && k <= 8) chk("rd_addr", memory_address, base + 16'(2 * (k - 1)));
      chk("wr_data", write_data_array, (k >= 5 && k <= 12));
      if (k >= 5 && k <= 12) begin
        chk("idx", fill_word_idx, k - 5);
        chk("fill_data", fill_data, (base + 16'(2 * (k - 5))) ^ 16'h5A5A);
      end
      chk("tag", write_tag_array, k == 12);
      if (k >= 1) chk("blk_addr", fill_block_addr, base);
    end
  endtask

  initial begin
    int t0, r0;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    #1;
    chk("rst_busy_follows_miss", fsm_busy, 1'b1);
    chk("rst_rd_en", memory_read_en, 1'b0);
    chk("rst_wr_data", write_data_array, 1'b0);
    chk("rst_tag", write_tag_array, 1'b0);
    chk("rst_blk_addr", fill_block_addr, 16'h0000);
`ifdef CACHE_FILL_PERF_CNT_EN
    chk("rst_fill_count", fill_count, 16'd0);
    chk("rst_busy_cycles", busy_cycles, 16'd0);
`endif
    miss_detected = 1'b0;
    rst = 1'b0;

    // Basic fill at latency 4.
    step(1'b0, 16'h0000);
    do_fill(16'h1236, 16'h1230);
`ifdef CACHE_FILL_PERF_CNT_EN
    chk("pc_fill1", fill_count, 16'd1);
    chk("pc_busy1", busy_cycles, 16'd13);
`endif

    // Top-of-address-space block, no wrap.
    do_fill(16'hFFFE, 16'hFFF0);
`ifdef CACHE_FILL_PERF_CNT_EN
    chk("pc_fill2", fill_count, 16'd2);
    chk("pc_busy2", busy_cycles, 16'd26);
`endif

    // Stray return while idle.
    step(1'b0, 16'h0000);
    memory_data_valid = 1'b1;
    memory_data = 16'hBEEF;
    #1;
    chk("stray_wr_data", write_data_array, 1'b0);
    chk("stray_tag", write_tag_array, 1'b0);
    chk("stray_busy", fsm_busy, 1'b0);
    chk("stray_blk_addr", fill_block_addr, 16'hFFF0);

    // Miss held high for the whole fill.
    r0 = reads_seen;
    t0 = tags_seen;
    for (int k = 0; k <= 12; k++) step(1'b1, 16'h0046);
    chk("held_tag_at_12", write_tag_array, 1'b1);
    step(1'b1, 16'h0100);
    chk("held_reads", reads_seen - r0, 8);
    chk("held_tags", tags_seen - t0, 1);
    chk("held_busy_13", fsm_busy, 1'b1);
    chk("held_rd_en_13", memory_read_en, 1'b0);
    chk("held_blk_13", fill_block_addr, 16'h0040);
    step(1'b0, 16'h0000);
    chk("held2_rd_en", memory_read_en, 1'b1);
    chk("held2_rd_addr", memory_address, 16'h0100);
    chk("held2_blk", fill_block_addr, 16'h0100);
    for (int k = 15; k <= 26; k++) step(1'b0, 16'h0000);
    chk("held2_tags", tags_seen - t0, 2);
    chk("held2_idle", fsm_busy, 1'b0);

    // Reset after three data writes aborts the fill.
    t0 = tags_seen;
    for (int k = 0; k <= 7; k++) step(k == 0, 16'h1236);
    chk("abort_third_write", write_data_array, 1'b1);
    chk("abort_third_idx", fill_word_idx, 3'd2);
    miss_detected = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", fsm_busy, 1'b0);
    chk("abort_rd_en", memory_read_en, 1'b0);
    chk("abort_wr_data", write_data_array, 1'b0);
    chk("abort_tag", write_tag_array, 1'b0);
    chk("abort_blk", fill_block_addr, 16'h0000);
    chk("abort_no_tag", tags_seen - t0, 0);
`ifdef CACHE_FILL_PERF_CNT_EN
    chk("abort_fill_count", fill_count, 16'd0);
`endif
    q.delete();
    memory_data_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_fill(16'h0000, 16'h0000);
`ifdef CACHE_FILL_PERF_CNT_EN
    chk("post_abort_fill_count", fill_count, 16'd1);
    chk("post_abort_busy", busy_cycles, 16'd13);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
